// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory req/ack, decoder valid/ready and
// control-unit redirect/halt signals, seen from the fetch stage (master).
interface instruction_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic [15:0]       instruction;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              halt;
    logic              halted;

    modport master (
        output mem_req, mem_addr, instruction, instr_pc, instr_valid, halted,
        input  mem_ack, mem_rdata, instr_ready, jump_en, jump_target, halt
    );

    modport slave (
        input  mem_req, mem_addr, instruction, instr_pc, instr_valid, halted,
        output mem_ack, mem_rdata, instr_ready, jump_en, jump_target, halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// VR16 instruction fetch stage: owns the PC, fetches words over req/ack and
// buffers {word, pc} pairs in a small FIFO ahead of the decoder.
module instruction_fetch #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        REDIRECT,
        FETCH,
        HALTED
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [15:0]       buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];

    logic push;
    logic pop;

    // Request is a pure decode of registered state, so instr_ready never reaches it.
    assign bus.mem_req     = (state == FETCH) && (count < FULL);
    assign bus.mem_addr    = pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instruction = buf_data[rd_ptr];
    assign bus.instr_pc    = buf_pc[rd_ptr];
    assign bus.halted      = (state == HALTED);

    assign push = bus.mem_req && bus.mem_ack;
    assign pop  = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= REDIRECT;
            pc     <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (state != HALTED) begin
            // Halt beats jump; both flush the buffer and drop any concurrent ack.
            if (bus.halt) begin
                state  <= HALTED;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else if (bus.jump_en) begin
                state  <= REDIRECT;
                pc     <= bus.jump_target;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else if (state == REDIRECT) begin
                state <= FETCH;
            end else begin
                if (push) begin
                    buf_data[wr_ptr] <= bus.mem_rdata;
                    buf_pc[wr_ptr]   <= pc;
                    wr_ptr           <= wr_ptr + PW'(1);
                    pc               <= pc + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instruction_fetch;
    localparam int AW    = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_ack = 1'b0;
    logic          instr_ready = 1'b0;
    logic          jump_en = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic          halt = 1'b0;

    int checks = 0;
    int failures = 0;

    instruction_fetch_if #(.ADDR_W(AW)) bus ();

    assign bus.mem_ack     = mem_ack;
    assign bus.mem_rdata   = 16'hA000 | 16'(bus.mem_addr);
    assign bus.instr_ready = instr_ready;
    assign bus.jump_en     = jump_en;
    assign bus.jump_target = jump_target;
    assign bus.halt        = halt;

    instruction_fetch #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {word, pc} the decoder should see, the PC,
    // an idle flag for the dead cycle after reset/jump, and a sticky halt.
    logic [16+AW-1:0] exp_q[$];
    logic [AW-1:0]    m_pc = '0;
    logic             m_idle = 1'b1;
    logic             m_halted = 1'b0;
    logic             do_push;
    logic             do_pop;

    function automatic logic modelReq();
        return !m_halted && !m_idle && (exp_q.size() < DEPTH);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_pc     = '0;
            m_idle   = 1'b1;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (halt) begin
            exp_q.delete();
            m_halted = 1'b1;
        end else if (jump_en) begin
            exp_q.delete();
            m_pc   = jump_target;
            m_idle = 1'b1;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            do_push = modelReq() && mem_ack;
            do_pop  = (exp_q.size() > 0) && instr_ready;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back({16'hA000 | 16'(m_pc), m_pc});
                m_pc = m_pc + 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("mdl_mem_req", 32'(bus.mem_req), 32'(modelReq()));
            checkOutput("mdl_mem_addr", 32'(bus.mem_addr), 32'(m_pc));
            checkOutput("mdl_instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() > 0));
            checkOutput("mdl_halted", 32'(bus.halted), 32'(m_halted));
            if (exp_q.size() > 0) begin
                checkOutput("mdl_instruction", 32'(bus.instruction), 32'(exp_q[0][16+AW-1:AW]));
                checkOutput("mdl_instr_pc", 32'(bus.instr_pc), 32'(exp_q[0][AW-1:0]));
            end
        end
    end

    // Drives one cycle of inputs, then returns 1 time unit after the next edge.
    task automatic applyStimulus(input logic ack, input logic rdy, input logic jmp,
                                 input logic [AW-1:0] tgt, input logic hlt);
        mem_ack     = ack;
        instr_ready = rdy;
        jump_en     = jmp;
        jump_target = tgt;
        halt        = hlt;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        mem_ack = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; halt = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        checkOutput({tag, "_instr_valid"}, 32'(bus.instr_valid), 0);
        checkOutput({tag, "_instruction"}, 32'(bus.instruction), 0);
        checkOutput({tag, "_instr_pc"}, 32'(bus.instr_pc), 0);
        checkOutput({tag, "_halted"}, 32'(bus.halted), 0);
    endtask

    initial begin
        int jumped;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("rst");
        reset = 1'b0;

        // Zero-wait stream, decoder always ready
        checkOutput("t1_c0_req", 32'(bus.mem_req), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t1_c1_req", 32'(bus.mem_req), 1);
        checkOutput("t1_c1_addr", 32'(bus.mem_addr), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t1_c2_valid", 32'(bus.instr_valid), 1);
        checkOutput("t1_c2_instr", 32'(bus.instruction), 32'hA000);
        checkOutput("t1_c2_pc", 32'(bus.instr_pc), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t1_c3_instr", 32'(bus.instruction), 32'hA001);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t1_c4_instr", 32'(bus.instruction), 32'hA002);

        // Back-pressure fills the buffer, then drains in order
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t2_full_req", 32'(bus.mem_req), 0);
        checkOutput("t2_full_addr", 32'(bus.mem_addr), 2);
        checkOutput("t2_head0", 32'(bus.instruction), 32'hA000);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t2_head1", 32'(bus.instruction), 32'hA001);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t2_head2", 32'(bus.instruction), 32'hA002);
        applyStimulus(1, 1, 0, 0, 0);

        // Slow memory, jump colliding with the ack for addr 5
        doReset();
        jumped = 0;
        for (int k = 0; k < 40; k++) begin
            if ((k % 3 == 2) && modelReq() && (m_pc == 8'd5)) begin
                applyStimulus(1, 1, 1, 8'h40, 0);
                jumped = 1;
                break;
            end
            applyStimulus(k % 3 == 2, 1, 0, 0, 0);
        end
        checkOutput("t3_jump_reached", 32'(jumped), 1);
        checkOutput("t3_n1_req", 32'(bus.mem_req), 0);
        checkOutput("t3_n1_valid", 32'(bus.instr_valid), 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t3_n2_req", 32'(bus.mem_req), 1);
        checkOutput("t3_n2_addr", 32'(bus.mem_addr), 32'h40);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t3_n3_valid", 32'(bus.instr_valid), 1);
        checkOutput("t3_n3_pc", 32'(bus.instr_pc), 32'h40);
        checkOutput("t3_n3_instr", 32'(bus.instruction), 32'hA040);

        // PC wrap from 0xFF
        applyStimulus(1, 1, 1, 8'hFF, 0);
        checkOutput("t4_n1_req", 32'(bus.mem_req), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t4_n2_addr", 32'(bus.mem_addr), 32'hFF);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t4_n3_addr", 32'(bus.mem_addr), 0);
        checkOutput("t4_n3_pc", 32'(bus.instr_pc), 32'hFF);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t4_n4_pc", 32'(bus.instr_pc), 0);
        checkOutput("t4_n4_instr", 32'(bus.instruction), 32'hA000);

        // Halt with two entries buffered, then a jump that must be ignored
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t5_pre_valid", 32'(bus.instr_valid), 1);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("t5_halted", 32'(bus.halted), 1);
        checkOutput("t5_valid", 32'(bus.instr_valid), 0);
        checkOutput("t5_req", 32'(bus.mem_req), 0);
        applyStimulus(1, 1, 1, 8'h33, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t5_jmp_req", 32'(bus.mem_req), 0);
        checkOutput("t5_jmp_addr", 32'(bus.mem_addr), 2);
        checkOutput("t5_jmp_halted", 32'(bus.halted), 1);
        doReset();
        checkAllZero("t5_rst");

        // Asynchronous reset between edges while a request is pending
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t6_pend_req", 32'(bus.mem_req), 1);
        checkOutput("t6_pend_addr", 32'(bus.mem_addr), 1);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("t6_async");
        doReset();
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t6_restart_req", 32'(bus.mem_req), 1);
        checkOutput("t6_restart_addr", 32'(bus.mem_addr), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t6_restart_instr", 32'(bus.instruction), 32'hA000);
        applyStimulus(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the VR16 core, sitting directly upstream of the instruction decoder. It owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and buffers them in a small FIFO. It presents them to the decoder with a valid/ready handshake. It also handles jump redirects and halt from the control unit.

## Interface
- `ADDR_W`, default 8: program counter / instruction memory address width; PC wraps modulo 2^ADDR_W.
- `DEPTH`, default 2: instruction buffer entries (power of two, ≥2).
- `clk` in, 1 bit: single clock, rising edge.
- `reset` in, 1 bit: asynchronous, active-high; clears all state immediately.
- `mem_req` out, 1 bit: fetch request to instruction memory.
- `mem_addr` out, ADDR_W bits: fetch address, equal to PC.
- `mem_ack` in, 1 bit: memory returns data this cycle; meaningful only while `mem_req`=1.
- `mem_rdata` in, 16 bits: instruction word, sampled when `mem_req && mem_ack`.
- `instruction` out, 16 bits: head-of-buffer instruction word to the decoder.
- `instr_pc` out, ADDR_W bits: address the head instruction was fetched from.
- `instr_valid` out, 1 bit: buffer non-empty.
- `instr_ready` in, 1 bit: decoder accepts the head entry this cycle.
- `jump_en` in, 1 bit: one-cycle redirect request from the control unit.
- `jump_target` in, ADDR_W bits: new PC, sampled when `jump_en`=1.
- `halt` in, 1 bit: stop fetching permanently until reset.
- `halted` out, 1 bit: block is in HALTED state.

## Operation
- States: REDIRECT (idle one cycle, no request), FETCH, HALTED.
- Reset values: state=REDIRECT, pc=0, count=0, `mem_req`=0, `mem_addr`=0, `instr_valid`=0, `instruction`=0, `instr_pc`=0, `halted`=0.
- Transitions, checked in priority order:
  - `halt` from any state → HALTED.
  - Else `jump_en` → REDIRECT.
  - Else REDIRECT → FETCH.
  - HALTED exits only on reset.
- `mem_req` = (state==FETCH) && (count < DEPTH), decoded from registered state. It stays high with `mem_addr` stable until `mem_ack`. It may only drop without ack on jump or halt; memory must tolerate abandonment.
- Fetch completion (`mem_req && mem_ack`, no jump/halt that cycle):
  - Push {`mem_rdata`, pc} into the buffer.
  - pc <= pc+1, wrapping from 2^ADDR_W−1 to 0.
  - Back-to-back acks give one fetch per cycle.
- Pop on `instr_valid && instr_ready`. Push and pop in the same cycle leave count unchanged. No push is possible when full, because `mem_req` is low.
- Jump, in the cycle `jump_en`=1:
  - Buffer flushed (count<=0) and pc<=`jump_target`.
  - A concurrent ack is discarded with no pc increment, and a concurrent pop has no further effect.
  - The next cycle is REDIRECT with `mem_req`=0; the first request at `jump_target` follows in the cycle after that.
- Jump while already in REDIRECT: accepted again; pc updates and the block stays in REDIRECT for one more cycle.
- Halt: buffer flushed, concurrent ack discarded, pc frozen, `mem_req`=0, `instr_valid`=0, `halted`=1. `jump_en` is ignored while halted or in the same cycle as `halt`.
- Reset mid-transfer: the outstanding request is abandoned and buffer contents are lost.

## Timing
- All state updates happen on the rising `clk` edge; `reset` acts asynchronously.
- Cycle 0 is the first cycle with `reset` low: REDIRECT, `mem_req`=0.
- Cycle 1: `mem_req`=1, `mem_addr`=0.
- With zero-wait memory (ack in cycle 1), `instr_valid`=1 with `instr_pc`=0 in cycle 2.
- Fetch-to-decoder latency is 1 cycle after the ack cycle.
- Jump asserted in cycle N:
  - N+1: REDIRECT, `instr_valid`=0.
  - N+2: `mem_req` at `jump_target`.
  - N+3: earliest valid instruction.
- `halt` in cycle N: `halted`=1 and `instr_valid`=0 from cycle N+1.
- Outputs are fed directly from registers or the state decode; there is no combinational path from `instr_ready` to `mem_req`.

## Test plan
- Zero-wait memory returning word = 0xA000|addr, `instr_ready`=1 throughout → decoder receives 0xA000, 0xA001, 0xA002… on consecutive cycles, first at cycle 2.
- `instr_ready`=0 for 5 cycles → exactly DEPTH=2 entries fetched (addr 0,1) and `mem_req` low while full. Releasing ready → 0xA000, 0xA001, 0xA002 delivered in order with no loss or duplication.
- Memory acks every 3rd cycle, jump to 0x40 asserted in the same cycle as an ack for addr 5 → that word is dropped, next `mem_addr`=0x40 two cycles later, next delivered `instr_pc`=0x40.
- pc preset by jump to 0xFF with ADDR_W=8 → fetches at 0xFF then 0x00 (wrap).
- `halt` asserted mid-stream with 2 entries buffered → `instr_valid`=0 and `halted`=1 next cycle; `mem_req` stays 0 and a subsequent `jump_en` has no effect; reset returns all outputs to 0.
- `reset` pulsed asynchronously between clock edges while `mem_req`=1 → all outputs 0 immediately; fetch restarts at addr 0.
